// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the image loader.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // Byte source plus memory write port (the environment side).
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  // The loader itself.
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: header word count, then little-endian
// 32-bit words written to consecutive word addresses; holds the core in reset
// until the whole image is in memory.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_rstn,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned BUF_W = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   word_idx;
  logic [1:0]         byte_idx;
  logic [BUF_W-1:0]   buffer;

  logic               xfer_c;
  logic               restart_c;
  logic [CNT_W-1:0]   hdr_n_c;
  logic [CNT_W-1:0]   word_inc_c;

  logic ready_d, we_d, cpu_rstn_d, busy_d, done_d, err_d;

  assign xfer_c     = bus.byte_valid & bus.byte_ready;
  assign restart_c  = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));
  assign hdr_n_c    = {bus.byte_data, cnt[7:0]};
  assign word_inc_c = CNT_W'(word_idx + CNT_W'(1));

  // State register and registered status/handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      bus.byte_ready <= 1'b0;
      bus.mem_we <= 1'b0;
      cpu_rstn   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      bus.byte_ready <= ready_d;
      bus.mem_we <= we_d;
      cpu_rstn   <= cpu_rstn_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start) state_d = S_HDR0;
      S_HDR0:  if (xfer_c) state_d = S_HDR1;
      S_HDR1: begin
        if (xfer_c) begin
          if (hdr_n_c == '0)                          state_d = S_DONE;
          else if (32'(hdr_n_c) > 32'(MAX_WORDS))     state_d = S_ERROR;
          else                                        state_d = S_DATA;
        end
      end
      S_DATA:  if (xfer_c && (byte_idx == 2'd3)) state_d = S_WRITE;
      S_WRITE: state_d = (word_inc_c == cnt) ? S_DONE : S_DATA;
      S_DONE,
      S_ERROR: if (start) state_d = S_HDR0;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    ready_d    = 1'b0;
    we_d       = 1'b0;
    cpu_rstn_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_d)
      S_HDR0, S_HDR1, S_DATA: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_WRITE: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
      end
      S_DONE: begin
        cpu_rstn_d = 1'b1;
        done_d     = 1'b1;
      end
      S_ERROR: err_d = 1'b1;
      default: ;
    endcase
  end

  // Header count, word assembly and write address/data registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt           <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      buffer        <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      if (restart_c) begin
        word_idx <= '0;
        byte_idx <= '0;
      end
      if (xfer_c) begin
        case (state)
          S_HDR0: cnt[7:0]  <= bus.byte_data;
          S_HDR1: cnt[15:8] <= bus.byte_data;
          S_DATA: begin
            buffer[{byte_idx, 3'b000} +: 8] <= bus.byte_data;
            byte_idx <= 2'(byte_idx + 2'd1);
            if (byte_idx == 2'd3) begin
              bus.mem_addr  <= {14'b0, word_idx, 2'b00};
              bus.mem_wdata <= {bus.byte_data, buffer[23:0]};
            end
          end
          default: ;
        endcase
      end
      if (state == S_WRITE) word_idx <= word_inc_c;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: byte streams are built from word lists
// (little-endian), and the observed memory writes are compared with i*4 / word[i].
module tb_imem_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic start = 1'b0;
  logic cpu_rstn, busy, done, err;

  imem_loader_if bus();

  imem_loader #(.MAX_WORDS(1024)) dut (
    .clk(clk), .rstn(rstn), .start(start), .bus(bus),
    .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Write log collected on the falling edge.
  wr_t  wr_q[$];
  wr_t  wr_tmp;
  int   ncyc = 0;
  int   done_cyc = -1;
  int   bad_ready = 0;
  int   bad_we = 0;
  logic done_prev = 1'b0;
  logic we_prev = 1'b0;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (bus.mem_we === 1'b1) begin
      wr_tmp.addr = bus.mem_addr;
      wr_tmp.data = bus.mem_wdata;
      wr_tmp.cyc  = ncyc;
      wr_q.push_back(wr_tmp);
      if (bus.byte_ready !== 1'b0) bad_ready = bad_ready + 1;
      if (we_prev === 1'b1) bad_we = bad_we + 1;
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_cyc = ncyc;
    done_prev = done;
    we_prev   = bus.mem_we;
  end

  task automatic clear_log();
    wr_q.delete();
    done_cyc  = -1;
    bad_ready = 0;
    bad_we    = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after a rising edge; leaves at the same phase.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic build_stream(input int n, input wq_t words, output bq_t b);
    b = {};
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) b.push_back(8'(words[i] >> (8 * k)));
    end
  endtask

  // Streams bytes with byte_valid high pct% of cycles; optional one-cycle start
  // pulse when byte index start_at is next to go. Returns just after the last transfer edge.
  task automatic send_bytes(input bq_t bytes, input int pct, input int start_at);
    int   i = 0;
    int   guard = 0;
    bit   st_done = 1'b0;
    logic v, r;
    while (i < bytes.size()) begin
      if (i == start_at && !st_done) begin
        start = 1'b1;
        st_done = 1'b1;
      end else begin
        start = 1'b0;
      end
      bus.byte_valid = ($urandom_range(99) < pct);
      bus.byte_data  = bus.byte_valid ? bytes[i] : 8'($urandom);
      @(negedge clk);
      v = bus.byte_valid;
      r = bus.byte_ready;
      @(posedge clk);
      if (v && r === 1'b1) i++;
      #1;
      guard++;
      if (guard > 20000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_bytes: stream stalled, sent %0d of required %0d bytes", i, bytes.size());
        break;
      end
    end
    start = 1'b0;
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.byte_ready, bus.mem_we, cpu_rstn, busy, done, err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 000000",
               {bus.byte_ready, bus.mem_we, cpu_rstn, busy, done, err});
    end
    n_cmp++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_bus: addr %h data %h required 0/0", bus.mem_addr, bus.mem_wdata);
    end
    do_reset();
    n_cmp++;
    if (busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy %b ready %b required 0/0", busy, bus.byte_ready);
    end
  endtask

  task automatic test_basic(input int pct, input string tag);
    wq_t words;
    bq_t b;
    bit  ok;
    words = {32'h003101B3, 32'h40828233};
    build_stream(2, words, b);
    clear_log();
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || bus.byte_ready !== 1'b1 || cpu_rstn !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_hdr_entry: busy %b ready %b cpu_rstn %b required 1/1/0", tag, busy, bus.byte_ready, cpu_rstn);
    end
    send_bytes(b, pct, -1);
    wait_done(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s_done_timeout: done never rose", tag);
    end
    n_cmp++;
    if (wr_q.size() != 2) begin
      n_bad++;
      $display("FAIL %s_write_count: got %0d required 2", tag, wr_q.size());
    end
    for (int i = 0; i < wr_q.size() && i < 2; i++) begin
      n_cmp++;
      if (wr_q[i].addr !== 32'(i * 4) || wr_q[i].data !== words[i]) begin
        n_bad++;
        $display("FAIL %s_write%0d: got %h@%h required %h@%h", tag, i,
                 wr_q[i].data, wr_q[i].addr, words[i], 32'(i * 4));
      end
    end
    n_cmp++;
    if (bad_ready != 0 || bad_we != 0) begin
      n_bad++;
      $display("FAIL %s_write_cycle: ready_during_we %0d long_we %0d required 0/0", tag, bad_ready, bad_we);
    end
    if (wr_q.size() == 2) begin
      n_cmp++;
      if (done_cyc != wr_q[1].cyc + 1) begin
        n_bad++;
        $display("FAIL %s_release_timing: done at cycle %0d required %0d", tag, done_cyc, wr_q[1].cyc + 1);
      end
    end
    n_cmp++;
    if (cpu_rstn !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_final: cpu_rstn %b done %b busy %b required 1/1/0", tag, cpu_rstn, done, busy);
    end
  endtask

  task automatic test_zero_length();
    bq_t b;
    b = {8'h00, 8'h00};
    clear_log();
    pulse_start();
    send_bytes(b, 100, -1);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || cpu_rstn !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_len_done: done %b cpu_rstn %b busy %b required 1/1/0", done, cpu_rstn, busy);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_q.size() != 0) begin
      n_bad++;
      $display("FAIL zero_len_writes: got %0d required 0", wr_q.size());
    end
  endtask

  task automatic test_oversize();
    bq_t b;
    b = {8'h01, 8'h04};
    clear_log();
    pulse_start();
    send_bytes(b, 100, -1);
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cpu_rstn !== 1'b0) begin
      n_bad++;
      $display("FAIL oversize_err: err %b busy %b done %b cpu_rstn %b required 1/0/0/0", err, busy, done, cpu_rstn);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_q.size() != 0 || cpu_rstn !== 1'b0) begin
      n_bad++;
      $display("FAIL oversize_writes: writes %0d cpu_rstn %b required 0/0", wr_q.size(), cpu_rstn);
    end
    // N equal to capacity is accepted.
    b = {8'h00, 8'h04};
    pulse_start();
    send_bytes(b, 100, -1);
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b1 || bus.byte_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL max_words_accept: err %b busy %b ready %b required 0/1/1", err, busy, bus.byte_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midload();
    wq_t words;
    bq_t b, part;
    bit  ok;
    do_reset();
    words = {};
    for (int i = 0; i < 3; i++) words.push_back($urandom | 32'h1);
    build_stream(3, words, b);
    part = b[0:7];
    clear_log();
    pulse_start();
    send_bytes(part, 100, -1);
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.byte_ready, bus.mem_we, cpu_rstn, busy, done, err} !== 6'b0 ||
        bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL midload_async_reset: flags %b addr %h data %h required all zero",
               {bus.byte_ready, bus.mem_we, cpu_rstn, busy, done, err}, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    pulse_start();
    send_bytes(b, 100, -1);
    wait_done(ok);
    n_cmp++;
    if (!ok || wr_q.size() != 3) begin
      n_bad++;
      $display("FAIL midload_reload: done %b writes %0d required 1/3", ok, wr_q.size());
    end
    for (int i = 0; i < wr_q.size() && i < 3; i++) begin
      n_cmp++;
      if (wr_q[i].addr !== 32'(i * 4) || wr_q[i].data !== words[i]) begin
        n_bad++;
        $display("FAIL midload_write%0d: got %h@%h required %h@%h", i,
                 wr_q[i].data, wr_q[i].addr, words[i], 32'(i * 4));
      end
    end
  endtask

  task automatic test_reload();
    bq_t b;
    bit  ok;
    b = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    clear_log();
    pulse_start();
    n_cmp++;
    if (cpu_rstn !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reload_entry: cpu_rstn %b done %b busy %b required 0/0/1", cpu_rstn, done, busy);
    end
    send_bytes(b, 100, -1);
    wait_done(ok);
    n_cmp++;
    if (!ok || wr_q.size() != 1) begin
      n_bad++;
      $display("FAIL reload_count: done %b writes %0d required 1/1", ok, wr_q.size());
    end else begin
      n_cmp++;
      if (wr_q[0].addr !== 32'h0 || wr_q[0].data !== 32'h00000013) begin
        n_bad++;
        $display("FAIL reload_write: got %h@%h required 00000013@00000000", wr_q[0].data, wr_q[0].addr);
      end
    end
  endtask

  task automatic test_start_busy();
    wq_t words;
    bq_t b;
    bit  ok;
    words = {};
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    build_stream(3, words, b);
    clear_log();
    pulse_start();
    send_bytes(b, 100, 7);
    wait_done(ok);
    n_cmp++;
    if (!ok || wr_q.size() != 3) begin
      n_bad++;
      $display("FAIL start_busy_count: done %b writes %0d required 1/3", ok, wr_q.size());
    end
    for (int i = 0; i < wr_q.size() && i < 3; i++) begin
      n_cmp++;
      if (wr_q[i].addr !== 32'(i * 4) || wr_q[i].data !== words[i]) begin
        n_bad++;
        $display("FAIL start_busy_write%0d: got %h@%h required %h@%h", i,
                 wr_q[i].data, wr_q[i].addr, words[i], 32'(i * 4));
      end
    end
  endtask

  task automatic test_random();
    wq_t words;
    bq_t b;
    bit  ok;
    int  n;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(6, 1);
      words = {};
      for (int i = 0; i < n; i++) words.push_back($urandom);
      build_stream(n, words, b);
      clear_log();
      pulse_start();
      send_bytes(b, $urandom_range(100, 30), -1);
      wait_done(ok);
      n_cmp++;
      if (!ok || wr_q.size() != n || bad_ready != 0 || bad_we != 0) begin
        n_bad++;
        $display("FAIL random%0d_count: done %b writes %0d required 1/%0d (ready_during_we %0d long_we %0d)",
                 it, ok, wr_q.size(), n, bad_ready, bad_we);
      end
      for (int i = 0; i < wr_q.size() && i < n; i++) begin
        n_cmp++;
        if (wr_q[i].addr !== 32'(i * 4) || wr_q[i].data !== words[i]) begin
          n_bad++;
          $display("FAIL random%0d_write%0d: got %h@%h required %h@%h", it, i,
                   wr_q[i].data, wr_q[i].addr, words[i], 32'(i * 4));
        end
      end
    end
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_basic(100, "basic");
    test_basic(50, "backpressure");
    test_zero_length();
    test_oversize();
    test_reset_midload();
    test_reload();
    test_start_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
